alu_rr_sequencer: RTL and testbench

- Hardwired control sequencer for register-register ALU instructions; drives the existing datapath's control strobes.
- Replaces hand-sequenced strobe generation with a synthesizable FSM.
- Generalised in register-file size, memory wait-states (Read/mem_ready handshake), two-result MUL/DIV mode (HI/LO writeback) and continuous-run mode.
- Fetches, decodes and executes one instruction per start, or back-to-back while run is high.

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/reg_onehot_dec.sv | 20 ++
 rtl/alu_rr_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the ALU register-register sequencer.
// State encoding, opcode constants and IR field positions.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    FAULT
  } state_t;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_MUL    = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV    = 5'b10000;
  localparam logic [OP_W-1:0] OP_MAX_RR = 5'b01110;

  localparam int IDX_W = 4;
  localparam int OP_HI = 31;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot select decoder.
// Indices at or above N produce an all-zero bus.
module reg_onehot_dec #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic          en,
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // one bit per register, only when enabled
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Hardwired fetch/decode/execute control for reg-reg ALU ops.
// Outputs decode only the state register and latched IR fields.
module alu_rr_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OP_W = cpu_ctrl_pkg::OP_W,
  parameter logic [OP_W-1:0] OP_MUL = cpu_ctrl_pkg::OP_MUL,
  parameter logic [OP_W-1:0] OP_DIV = cpu_ctrl_pkg::OP_DIV,
  parameter logic [OP_W-1:0] OP_MAX_RR = cpu_ctrl_pkg::OP_MAX_RR
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  import cpu_ctrl_pkg::*;

  state_t state, nxt;

  logic [OP_W-1:0]  op_q;
  logic [IDX_W-1:0] ra_q, rb_q, rc_q;

  logic [OP_W-1:0]  op_in;
  logic [IDX_W-1:0] ra_in, rb_in, rc_in;
  logic             bad_in;
  logic             two_res;

  logic             rin_en;
  logic             rout_en;
  logic [IDX_W-1:0] rout_idx;

  assign op_in = IR[OP_HI -: OP_W];
  assign ra_in = IR[RA_HI:RA_LO];
  assign rb_in = IR[RB_HI:RB_LO];
  assign rc_in = IR[RC_HI:RC_LO];

  assign bad_in = (op_in > OP_MAX_RR &&
                   op_in != OP_MUL &&
                   op_in != OP_DIV) ||
                  int'(ra_in) >= NUM_REGS ||
                  int'(rb_in) >= NUM_REGS ||
                  int'(rc_in) >= NUM_REGS;

  assign two_res = (op_q == OP_MUL) ||
                   (op_q == OP_DIV);

  // state register and IR field latch on leaving T2
  always_ff @(posedge Clock) begin
    if (clear) begin
      state <= IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= nxt;
      if (state == T2) begin
        op_q <= op_in;
        ra_q <= ra_in;
        rb_q <= rb_in;
        rc_q <= rc_in;
      end
    end
  end

  // next state and strobe decode
  always_comb begin
    nxt      = state;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    alu_op   = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = rb_q;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) nxt = T0;
      end
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
        nxt   = T1;
      end
      T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) nxt = T2;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        nxt    = bad_in ? FAULT : T3;
      end
      T3: begin
        rout_en  = 1'b1;
        rout_idx = rb_q;
        Yin      = 1'b1;
        nxt      = T4;
      end
      T4: begin
        rout_en  = 1'b1;
        rout_idx = rc_q;
        Zin      = 1'b1;
        alu_op   = op_q;
        nxt      = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        if (two_res) begin
          LOin = 1'b1;
          nxt  = T6;
        end else begin
          rin_en = 1'b1;
          done   = 1'b1;
          nxt    = run ? T0 : IDLE;
        end
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        nxt      = run ? T0 : IDLE;
      end
      FAULT: begin
        illegal = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  reg_onehot_dec #(
    .N  (NUM_REGS),
    .IW (IDX_W)
  ) u_rin (
    .en     (rin_en),
    .idx    (ra_q),
    .onehot (Rin)
  );

  reg_onehot_dec #(
    .N  (NUM_REGS),
    .IW (IDX_W)
  ) u_rout (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench for alu_rr_sequencer.
// Expected per-cycle strobe vectors are queued at start time.
module tb_alu_rr_sequencer;

  logic        Clock = 1'b0;
  logic        clear, start, run, mem_ready;
  logic [31:0] IR;

  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic busy, done, illegal;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;

  logic e_PCout, e_MARin, e_IncPC, e_PCin, e_Read, e_MDRin;
  logic e_MDRout, e_IRin, e_Yin, e_Zin, e_Zlowout, e_Zhighout;
  logic e_LOin, e_HIin, e_busy, e_done, e_illegal;
  logic [7:0] e_Rin, e_Rout;
  logic [4:0] e_alu_op;

  always #5 Clock = ~Clock;

  alu_rr_sequencer #(.NUM_REGS(16)) dut (
    .Clock(Clock), .clear(clear), .start(start), .run(run),
    .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOin(LOin), .HIin(HIin), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  alu_rr_sequencer #(.NUM_REGS(8)) dut8 (
    .Clock(Clock), .clear(clear), .start(start), .run(run),
    .mem_ready(mem_ready), .IR(IR),
    .PCout(e_PCout), .MARin(e_MARin), .IncPC(e_IncPC),
    .PCin(e_PCin), .Read(e_Read), .MDRin(e_MDRin),
    .MDRout(e_MDRout), .IRin(e_IRin), .Yin(e_Yin), .Zin(e_Zin),
    .Zlowout(e_Zlowout), .Zhighout(e_Zhighout), .LOin(e_LOin),
    .HIin(e_HIin), .Rin(e_Rin), .Rout(e_Rout),
    .alu_op(e_alu_op), .busy(e_busy), .done(e_done),
    .illegal(e_illegal)
  );

  localparam int B_PCOUT = 16, B_MARIN = 15, B_INCPC = 14;
  localparam int B_PCIN = 13, B_READ = 12, B_MDRIN = 11;
  localparam int B_MDROUT = 10, B_IRIN = 9, B_YIN = 8;
  localparam int B_ZIN = 7, B_ZLO = 6, B_ZHI = 5, B_LOIN = 4;
  localparam int B_HIIN = 3, B_BUSY = 2, B_DONE = 1, B_ILL = 0;

  logic [53:0] obs;
  logic [3:0]  obs8;

  assign obs = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout,
                IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin,
                busy, done, illegal, alu_op, Rin, Rout};

  assign obs8 = {e_busy, e_illegal, e_Yin, e_Zin};

  typedef struct {
    logic [53:0] exp;
    logic        mr;
    logic        rn;
    logic [31:0] ir;
    string       tag;
    bit          chk8;
    logic [3:0]  exp8;
  } ent_t;

  ent_t  sb[$];
  int    tests = 0;
  int    fails = 0;
  string cur_test = "";

  function automatic logic [31:0] mk_ir(input int op, input int ra,
                                        input int rb, input int rc);
    logic [31:0] v;
    v = '0;
    v[31:27] = 5'(op);
    v[26:23] = 4'(ra);
    v[22:19] = 4'(rb);
    v[18:15] = 4'(rc);
    return v;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic add(input logic [16:0] s, input logic [4:0] aop,
                     input logic [15:0] rin, input logic [15:0] rout,
                     input logic mr, input logic rn,
                     input logic [31:0] ir, input string tag);
    ent_t e;
    e.exp  = {s, aop, rin, rout};
    e.mr   = mr;
    e.rn   = rn;
    e.ir   = ir;
    e.tag  = {cur_test, ":", tag};
    e.chk8 = 1'b0;
    e.exp8 = '0;
    sb.push_back(e);
  endtask

  task automatic push_instr(input logic [31:0] ir, input int dly,
                            input bit run_after);
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [16:0] s;
    bit          two, bad;
    op  = ir[31:27];
    ra  = ir[26:23];
    rb  = ir[22:19];
    rc  = ir[18:15];
    two = (op == 5'd15) || (op == 5'd16);
    bad = (op > 5'd14) && !two;
    s = '0;
    s[B_BUSY] = 1; s[B_PCOUT] = 1; s[B_MARIN] = 1;
    s[B_INCPC] = 1; s[B_PCIN] = 1;
    add(s, 5'd0, 16'd0, 16'd0, 1'b1, 1'b0, ir, "T0");
    for (int k = 0; k <= dly; k++) begin
      s = '0;
      s[B_BUSY] = 1; s[B_READ] = 1; s[B_MDRIN] = 1;
      add(s, 5'd0, 16'd0, 16'd0, (k == dly), 1'b0, ir, "T1");
    end
    s = '0;
    s[B_BUSY] = 1; s[B_MDROUT] = 1; s[B_IRIN] = 1;
    add(s, 5'd0, 16'd0, 16'd0, 1'b1, 1'b0, ir, "T2");
    if (bad) begin
      s = '0;
      s[B_BUSY] = 1; s[B_ILL] = 1;
      add(s, 5'd0, 16'd0, 16'd0, 1'b1, 1'b0, ir, "FAULT");
      add(17'd0, 5'd0, 16'd0, 16'd0, 1'b1, 1'b0, ir, "IDLE");
      return;
    end
    s = '0;
    s[B_BUSY] = 1; s[B_YIN] = 1;
    add(s, 5'd0, 16'd0, oh(rb), 1'b1, 1'b0, ir, "T3");
    s = '0;
    s[B_BUSY] = 1; s[B_ZIN] = 1;
    add(s, op, 16'd0, oh(rc), 1'b1, 1'b0, ir, "T4");
    if (two) begin
      s = '0;
      s[B_BUSY] = 1; s[B_ZLO] = 1; s[B_LOIN] = 1;
      add(s, 5'd0, 16'd0, 16'd0, 1'b1, 1'b0, ir, "T5");
      s = '0;
      s[B_BUSY] = 1; s[B_ZHI] = 1; s[B_HIIN] = 1; s[B_DONE] = 1;
      add(s, 5'd0, 16'd0, 16'd0, 1'b1, run_after, ir, "T6");
    end else begin
      s = '0;
      s[B_BUSY] = 1; s[B_ZLO] = 1; s[B_DONE] = 1;
      add(s, 5'd0, oh(ra), 16'd0, 1'b1, run_after, ir, "T5");
    end
    if (!run_after)
      add(17'd0, 5'd0, 16'd0, 16'd0, 1'b1, 1'b0, ir, "IDLE");
  endtask

  task automatic drain();
    ent_t e;
    while (sb.size() > 0) begin
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      start     = 1'b0;
      mem_ready = e.mr;
      run       = e.rn;
      IR        = e.ir;
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.exp);
      end
      if (e.chk8) begin
        tests++;
        assert (obs8 === e.exp8) else begin
          fails++;
          $error("FAIL %s/n8 obs=%b exp=%b", e.tag, obs8, e.exp8);
        end
      end
    end
  endtask

  task automatic go(input string name);
    cur_test = name;
    start = 1'b1;
  endtask

  initial begin
    clear     = 1'b1;
    start     = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    IR        = '0;
    repeat (2) @(posedge Clock);
    #1;
    clear = 1'b0;
    tests++;
    assert (obs === 54'd0) else begin
      fails++;
      $error("FAIL reset obs=%h exp=0", obs);
    end
    tests++;
    assert (obs8 === 4'd0) else begin
      fails++;
      $error("FAIL reset/n8 obs=%b exp=0", obs8);
    end

    go("clr_t4");
    push_instr(mk_ir(5, 1, 2, 3), 0, 1'b0);
    while (sb.size() > 5) void'(sb.pop_back());
    drain();
    clear = 1'b1;
    @(posedge Clock);
    #1;
    clear = 1'b0;
    tests++;
    assert (obs === 54'd0) else begin
      fails++;
      $error("FAIL clr_t4 obs=%h exp=0", obs);
    end

    go("basic");
    push_instr(32'h28918000, 0, 1'b0);
    drain();

    go("wait3");
    push_instr(32'h28918000, 3, 1'b0);
    drain();

    go("mul");
    push_instr(mk_ir(15, 0, 4, 5), 0, 1'b0);
    drain();

    go("div");
    push_instr(mk_ir(16, 3, 1, 2), 0, 1'b0);
    drain();

    go("opmax");
    push_instr(mk_ir(14, 15, 15, 15), 0, 1'b0);
    drain();

    go("ill31");
    push_instr(32'hF8000000, 0, 1'b0);
    drain();

    go("ill17");
    push_instr(mk_ir(17, 1, 1, 1), 1, 1'b1);
    drain();

    go("run");
    push_instr(mk_ir(3, 2, 5, 6), 0, 1'b1);
    push_instr(mk_ir(1, 7, 1, 0), 1, 1'b0);
    drain();

    go("n8_rb9");
    push_instr(mk_ir(5, 1, 9, 3), 0, 1'b0);
    for (int i = 0; i < sb.size(); i++) sb[i].chk8 = 1'b1;
    sb[0].exp8 = 4'b1000;
    sb[1].exp8 = 4'b1000;
    sb[2].exp8 = 4'b1000;
    sb[3].exp8 = 4'b1100;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
